des_ip_ingress: RTL and testbench
=================================

// Module: des_ip_ingress
// PURPOSE
// - Input end of the DES datapath: collects plaintext/ciphertext as a byte stream and assembles 64-bit blocks.
// - Applies the DES initial permutation (IP), the exact inverse of the final permutation, and splits the result into L0/R0.
// - Queues blocks in a small FIFO; the round engine pops them with valid/ready.
// PARAMETERS
// - FIFO_DEPTH  2  block entries after IP; power of two, >=2
// PORTS
// - clk        in   1   single clock, rising edge
// - rst_n      in   1   reset; asynchronous assert, active-low
// - in_valid   in   1   byte present on in_byte
// - in_ready   out  1   ingress can accept a byte this cycle
// - in_byte    in   8   data byte; first byte of a block = DES bits 1..8 (MSB)
// - out_valid  out  1   FIFO head holds a permuted block
// - out_ready  in   1   round engine consumes the head
// - out_l      out  32  L0 = IP(block) DES bits 1..32
// - out_r      out  32  R0 = IP(block) DES bits 33..64
// - blk_cnt    out  16  blocks pushed since reset; wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (async, rst_n=0): byte counter=0, assembly reg=0, FIFO empty, out_valid=0, out_l/out_r=0, blk_cnt=0, in_ready=0 while in reset.
// - Byte transfer when in_valid&in_ready. Shift in left: asm = {asm[55:0], in_byte}, byte_cnt++.
// - On 8th byte (byte_cnt==7 accepted): IP(asm_next) is pushed to the FIFO in the same edge; byte_cnt returns to 0; blk_cnt++.
// - Latency: 8th byte accepted at edge N -> out_valid=1 after edge N (usable cycle N+1), if FIFO was empty.
// - IP: DES numbering, bit 1 = MSB [63]. out bit i = in bit IP[i]; IP row 1 = 58,50,42,34,26,18,10,2; rows follow the standard table.
// - in_ready = !(byte_cnt==7 && fifo_full). Registered terms only; a same-cycle pop does not raise it.
// - Bytes 0..6 of a block are always accepted, including while the FIFO is full.
// - FIFO: out_valid = !empty. Pop on out_valid&out_ready. out_l/out_r show the head; they hold their value while out_valid=1 and out_ready=0.
// - FIFO simultaneous push+pop when full: cannot occur (in_ready=0). Push+pop at any other fill level: count unchanged.
// - FIFO pointers wrap modulo FIFO_DEPTH. An empty pop or a full push is impossible by construction; assert this in simulation.
// - A reset mid-block discards the partial block and all queued blocks. No output appears from a partial block.
// - out_l/out_r while out_valid=0: last head value (don't care for consumers); the bench checks them only when valid.
// CONFIGURATION
// - DES_IP_FLUSH_EN defined:
//   - Adds port in_last (in,1) qualified with the byte transfer, and output out_last (out,1) stored per FIFO entry.
//   - A byte with in_last=1 closes the block. Missing bytes are zero-padded on the right (LSBs), IP is applied and the block is pushed that edge.
//   - The entry's out_last=1. byte_cnt returns to 0.
//   - in_ready with flush: = !(fifo_full && (byte_cnt==7 || in_last_pending)). Implement it as in_ready = !fifo_full whenever byte_cnt>0 is not tracked separately.
//   - Chosen rule: in_ready = !fifo_full when the macro is defined.
// - Undefined: no in_last/out_last ports; blocks close only after 8 bytes; in_ready as above.
// STRUCTURE
// - des_pkg (shared): DES_BLK_W=64, DES_HALF_W=32, IP and FP tables as localparam arrays, and function des_ip(input [63:0]) for reuse.
// - Sub-module des_ip_perm: purely combinational IP, instantiated once between the assembly register and the FIFO write port.
// - Top level: byte assembler + counter, FIFO storage (FIFO_DEPTH x 64 [+1 last bit]), rd/wr pointers, fill count.
// TESTING
// - Bytes 01 23 45 67 89 AB CD EF, out_ready=1 -> one block; out_l=32'hCC00CCFF, out_r=32'hF0AAF0AA; blk_cnt=1; out_valid exactly 1 cycle after the 8th byte.
// - Block 00 00 00 00 00 00 00 40 (DES bit 58) -> {out_l,out_r}=64'h8000_0000_0000_0000. All FF block -> all ones.
// - out_ready=0, stream 3 blocks (FIFO_DEPTH=2) -> 2 blocks queued; in_ready drops at byte 8 of block 3; 7 bytes are accepted. Raise out_ready -> blocks emerge in order and block 3 completes.
// - Random in_valid/out_ready stalls over 1000 blocks -> output matches the des_ip reference model in order, and blk_cnt matches.
// - rst_n pulse after 5 bytes of a block, asynchronous mid-cycle -> outputs zero immediately; the next 8 bytes form a clean block.
// - DES_IP_FLUSH_EN: bytes AA BB CC with in_last on CC -> IP(64'hAABBCC0000000000) with out_last=1. The following full block has out_last=0.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: block widths, IP/FP tables and permutation helpers.
// Used by the ingress datapath (des_ip_ingress, optional DES_IP_FLUSH_EN build).
package des_pkg;

  localparam int DES_BLK_W  = 64;
  localparam int DES_HALF_W = 32;

  // Tables use DES bit numbering: bit 1 is the MSB, bit 64 the LSB.
  localparam int unsigned IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  typedef struct packed {
    logic [DES_HALF_W-1:0] l;
    logic [DES_HALF_W-1:0] r;
  } des_lr_t;

  function automatic logic [DES_BLK_W-1:0] des_ip(input logic [DES_BLK_W-1:0] blk);
    logic [DES_BLK_W-1:0] res;
    res = '0;
    for (int i = 0; i < DES_BLK_W; i++)
      res[DES_BLK_W-1-i] = blk[DES_BLK_W-IP_TBL[i]];
    return res;
  endfunction

  function automatic logic [DES_BLK_W-1:0] des_fp(input logic [DES_BLK_W-1:0] blk);
    logic [DES_BLK_W-1:0] res;
    res = '0;
    for (int i = 0; i < DES_BLK_W; i++)
      res[DES_BLK_W-1-i] = blk[DES_BLK_W-FP_TBL[i]];
    return res;
  endfunction

endpackage

// File: rtl/des_ip_perm.sv
// Purely combinational DES initial permutation between the assembler and the FIFO.
module des_ip_perm
  import des_pkg::*;
(
  input  logic [DES_BLK_W-1:0] blk_in,
  output logic [DES_BLK_W-1:0] blk_out
);

  assign blk_out = des_ip(blk_in);

endmodule

// File: rtl/des_ip_ingress.sv
// DES ingress: byte assembler, initial permutation, block FIFO toward the round engine.
// Define DES_IP_FLUSH_EN to add in_last/out_last and zero-padded short blocks.
module des_ip_ingress
  import des_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
`ifdef DES_IP_FLUSH_EN
  input  logic                  in_last,
  output logic                  out_last,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DES_HALF_W-1:0] out_l,
  output logic [DES_HALF_W-1:0] out_r,
  output logic [15:0]           blk_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [2:0]           byte_cnt;
  logic [DES_BLK_W-1:0] asm_q;
  logic [DES_BLK_W-1:0] asm_next;
  logic [DES_BLK_W-1:0] blk_closed;
  des_lr_t              blk_perm;
  des_lr_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fill;
  logic                 xfer;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign fifo_full  = (fill == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fill == '0);
  assign asm_next   = {asm_q[DES_BLK_W-9:0], in_byte};
  assign xfer       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

`ifdef DES_IP_FLUSH_EN
  assign in_ready   = rst_n && !fifo_full;
  assign push       = xfer && ((byte_cnt == 3'd7) || in_last);
  // Short blocks keep their bytes at the MSB end; the missing bytes become zeros.
  assign blk_closed = asm_next << {3'd7 - byte_cnt, 3'b000};
`else
  // Only the block-closing byte needs a free slot; a same-cycle pop is ignored.
  assign in_ready   = rst_n && !((byte_cnt == 3'd7) && fifo_full);
  assign push       = xfer && (byte_cnt == 3'd7);
  assign blk_closed = asm_next;
`endif

  des_ip_perm u_perm (
    .blk_in  (blk_closed),
    .blk_out (blk_perm)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      asm_q    <= '0;
    end else if (xfer) begin
      asm_q    <= push ? '0 : asm_next;
      byte_cnt <= push ? '0 : byte_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      blk_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        blk_cnt <= blk_cnt + 16'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + CNT_W'(1);
        2'b01:   fill <= fill - CNT_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // NOTE: the storage is reset because out_l/out_r must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= blk_perm;
    end
  end

`ifdef DES_IP_FLUSH_EN
  logic last_mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        last_mem[i] <= 1'b0;
    end else if (push) begin
      last_mem[wr_ptr] <= in_last;
    end
  end

  assign out_last = last_mem[rd_ptr];
`endif

  assign out_valid = !fifo_empty;
  assign out_l     = mem[rd_ptr].l;
  assign out_r     = mem[rd_ptr].r;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && fifo_full));
      assert (!(pop && fifo_empty));
    end
  end

endmodule

// File: tb/tb_des_ip_ingress.sv
// Self-checking bench for des_ip_ingress: directed IP vectors, FIFO back-pressure,
// asynchronous reset mid-block, random stalls against an independent IP model.
`timescale 1ns/1ps
module tb_des_ip_ingress;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_l;
  logic [31:0] out_r;
  logic [15:0] blk_cnt;
`ifdef DES_IP_FLUSH_EN
  logic        in_last = 1'b0;
  logic        out_last;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_blk = 16'd0;

  des_ip_ingress #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
`ifdef DES_IP_FLUSH_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_l     (out_l),
    .out_r     (out_r),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] blk;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Row-structured IP: even source bits on the first four rows, odd bits after.
  function automatic logic [63:0] ref_ip(input logic [63:0] b);
    logic [63:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        src = (r < 4) ? (58 + 2*r - 8*c) : (57 + 2*(r-4) - 8*c);
        o[63 - (8*r + c)] = b[64 - src];
      end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("byte_accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk, input int nbytes);
    for (int k = 0; k < nbytes; k++)
      send_byte(blk[63-8*k -: 8]);
  endtask

  task automatic pop_head();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  localparam logic [63:0] BLK_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] BLK_B = 64'h0000000000000040;
  localparam logic [63:0] BLK_C = 64'h0000000000000001;
  localparam logic [63:0] IP_A  = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] IP_B  = 64'h80000000_00000000;
  localparam logic [63:0] IP_C  = 64'h00000080_00000000;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{BLK_A, 32'hCC00CCFF, 32'hF0AAF0AA, "ip_std"};
    vecs[1] = '{BLK_B, 32'h80000000, 32'h00000000, "ip_bit58"};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "ip_ones"};
    vecs[3] = '{64'h0000000000000000, 32'h00000000, 32'h00000000, "ip_zero"};
    vecs[4] = '{64'h8000000000000000, 32'h00000000, 32'h01000000, "ip_bit1"};
    vecs[5] = '{BLK_C, 32'h00000080, 32'h00000000, "ip_bit64"};

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_lr", {out_l, out_r}, 64'd0);
    check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven IP vectors, with latency and hold-while-stalled checks
    foreach (vecs[i]) begin
      send_block(vecs[i].blk, 7);
      check({vecs[i].name, "_pre_valid"}, 64'(out_valid), 64'd0);
      send_byte(vecs[i].blk[7:0]);
      exp_blk++;
      check({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
      check(vecs[i].name, {out_l, out_r}, {vecs[i].exp_l, vecs[i].exp_r});
      check({vecs[i].name, "_blk_cnt"}, 64'(blk_cnt), 64'(exp_blk));
      tick();
      check({vecs[i].name, "_hold"}, {out_l, out_r}, {vecs[i].exp_l, vecs[i].exp_r});
      pop_head();
      check({vecs[i].name, "_drained"}, 64'(out_valid), 64'd0);
    end

    // Back-pressure: two queued blocks, third block stalls at its 8th byte
    send_block(BLK_A, 8);
    send_block(BLK_B, 8);
    exp_blk += 16'd2;
    check("full_head_a", {out_l, out_r}, IP_A);
`ifdef DES_IP_FLUSH_EN
    check("full_in_ready", 64'(in_ready), 64'd0);
    pop_head();
    send_block(BLK_C, 8);
    exp_blk++;
`else
    send_block(BLK_C, 7);
    in_valid = 1'b1;
    in_byte  = BLK_C[7:0];
    for (int k = 0; k < 3; k++) begin
      check("full_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    check("full_blk_cnt_stalled", 64'(blk_cnt), 64'(exp_blk));
    pop_head();
    check("full_ready_after_pop", 64'(in_ready), 64'd1);
    check("full_no_push_on_pop", 64'(blk_cnt), 64'(exp_blk));
    tick();
    in_valid = 1'b0;
    exp_blk++;
`endif
    check("full_blk_cnt", 64'(blk_cnt), 64'(exp_blk));
    check("full_head_b", {out_l, out_r}, IP_B);
    pop_head();
    check("full_head_c", {out_l, out_r}, IP_C);
    pop_head();
    check("full_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-block with a queued block
    send_block(BLK_B, 8);
    send_block(BLK_A, 5);
    check("mid_queued", 64'(out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_lr", {out_l, out_r}, 64'd0);
    check("mid_rst_blk_cnt", 64'(blk_cnt), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b1;
    exp_blk = 16'd0;
    tick();
    send_block(BLK_A, 8);
    exp_blk++;
    check("mid_clean_blk", {out_l, out_r}, IP_A);
    check("mid_clean_cnt", 64'(blk_cnt), 64'(exp_blk));
    pop_head();

`ifdef DES_IP_FLUSH_EN
    // Short block closed by in_last, then a full block
    send_byte(8'hAA);
    send_byte(8'hBB);
    in_last = 1'b1;
    send_byte(8'hCC);
    in_last = 1'b0;
    exp_blk++;
    check("flush_blk", {out_l, out_r}, ref_ip(64'hAABBCC0000000000));
    check("flush_last", 64'(out_last), 64'd1);
    pop_head();
    send_block(BLK_A, 8);
    exp_blk++;
    check("flush_next_blk", {out_l, out_r}, IP_A);
    check("flush_next_last", 64'(out_last), 64'd0);
    pop_head();
`endif

    // Random stalls on both sides, scoreboard against ref_ip
    begin
      logic [63:0] exp_q [$];
      logic [63:0] cur_blk;
      logic        xfer;
      int          byte_idx;
      int          sent;
      int          recv;
      int          cyc;
      byte_idx = 0;
      sent     = 0;
      recv     = 0;
      cyc      = 0;
      cur_blk  = {$urandom, $urandom};
      while (recv < 1000 && cyc < 60000) begin
        in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
        in_byte   = cur_blk[63-8*byte_idx -: 8];
        out_ready = ($urandom_range(3) != 0);
        #1;
        xfer = in_valid && in_ready;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0)
            check("rand_extra_blk", 64'(exp_q.size()), 64'd1);
          else
            check("rand_blk", {out_l, out_r}, exp_q.pop_front());
          recv++;
        end
        tick();
        if (xfer) begin
          if (byte_idx == 7) begin
            exp_q.push_back(ref_ip(cur_blk));
            exp_blk++;
            sent++;
            byte_idx = 0;
            cur_blk  = {$urandom, $urandom};
          end else begin
            byte_idx++;
          end
        end
        cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (recv < 1000)
        check("rand_timeout_blocks", 64'(recv), 64'd1000);
      check("rand_blk_cnt", 64'(blk_cnt), 64'(exp_blk));
      check("rand_drained", 64'(out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
